// File: rtl/nms_window_gen.sv
// 3x3 magnitude window generator feeding NMS; two line buffers plus a 3x3 shift window; optional sof_in resync under NMS_WINDOW_SOF_EN.
// Latency 1 clk from the triggering pixel; no backpressure, so the downstream stage must accept every valid_out cycle.
module nms_window_gen #(
  parameter int W     = 12,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [W-1:0] mag_in,
  input  logic [3:0]   dir_in,
`ifdef NMS_WINDOW_SOF_EN
  input  logic         sof_in,
`endif
  output logic         valid_out,
  output logic [W-1:0] g0,
  output logic [W-1:0] g1,
  output logic [W-1:0] g2,
  output logic [W-1:0] g3,
  output logic [W-1:0] g4,
  output logic [W-1:0] g5,
  output logic [W-1:0] g6,
  output logic [W-1:0] g7,
  output logic [W-1:0] g8,
  output logic [3:0]   dir_out,
  output logic         eof_out
);

  localparam int PW = W + 4;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Each entry packs {dir, mag}; lb0 holds row y-1, lb1 holds row y-2.
  logic [PW-1:0] lb0_mem [IMG_W];
  logic [PW-1:0] lb1_mem [IMG_W];

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  logic [PW-1:0] win_q [3][3];
  logic [PW-1:0] win_d [3][3];
  logic [W-1:0]  out_mag_q [9];
  logic [W-1:0]  out_mag_d [9];
  logic [3:0]    out_dir_q, out_dir_d;
  logic          valid_out_q, valid_out_d;
  logic          eof_out_q, eof_out_d;

  logic          sof_hit;
  logic          last_col, last_row;
  logic [PW-1:0] pix_in, lb0_rd, lb1_rd;

`ifdef NMS_WINDOW_SOF_EN
  assign sof_hit = valid_in & sof_in;
`else
  assign sof_hit = 1'b0;
`endif

  // Position of the pixel being accepted this cycle; sof_in overrides the counters.
  always_comb begin
    x_cur    = sof_hit ? '0 : x_q;
    y_cur    = sof_hit ? '0 : y_q;
    last_col = (x_cur == XW'(IMG_W - 1));
    last_row = (y_cur == YW'(IMG_H - 1));
    pix_in   = {dir_in, mag_in};
    lb0_rd   = lb0_mem[x_cur];
    lb1_rd   = lb1_mem[x_cur];
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (valid_in) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_cur + YW'(1);
      end else begin
        x_d = x_cur + XW'(1);
        y_d = y_cur;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;
    end
  end

  // The x>=2 gate keeps every window inside one row span, so no wrap handling is needed.
  always_comb begin
    valid_out_d = valid_in && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    eof_out_d   = valid_in && last_col && last_row;
    out_dir_d   = out_dir_q;
    for (int k = 0; k < 9; k++) begin
      out_mag_d[k] = out_mag_q[k];
    end
    if (valid_out_d) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          out_mag_d[r*3 + c] = win_d[r][c][W-1:0];
        end
      end
      out_dir_d = win_d[1][1][PW-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      valid_out_q <= 1'b0;
      eof_out_q   <= 1'b0;
      out_dir_q   <= '0;
      for (int k = 0; k < 9; k++) begin
        out_mag_q[k] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      valid_out_q <= valid_out_d;
      eof_out_q   <= eof_out_d;
      out_dir_q   <= out_dir_d;
      for (int k = 0; k < 9; k++) begin
        out_mag_q[k] <= out_mag_d[k];
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // Line buffers are never cleared; stale rows are overwritten before any window uses them.
  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      lb1_mem[x_cur] <= lb0_rd;
      lb0_mem[x_cur] <= pix_in;
    end
  end

  assign valid_out = valid_out_q;
  assign eof_out   = eof_out_q;
  assign dir_out   = out_dir_q;
  assign g0        = out_mag_q[0];
  assign g1        = out_mag_q[1];
  assign g2        = out_mag_q[2];
  assign g3        = out_mag_q[3];
  assign g4        = out_mag_q[4];
  assign g5        = out_mag_q[5];
  assign g6        = out_mag_q[6];
  assign g7        = out_mag_q[7];
  assign g8        = out_mag_q[8];

endmodule

// File: tb/tb_nms_window_gen.sv
// Bench for nms_window_gen on a 5x4 image: per-cycle comparison against an image-array reference model.
module tb_nms_window_gen;

  localparam int WD = 12;
  localparam int IW = 5;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [WD-1:0] mag_in = '0;
  logic [3:0]    dir_in = '0;
`ifdef NMS_WINDOW_SOF_EN
  logic          sof_in = 1'b0;
`endif
  logic          valid_out, eof_out;
  logic [WD-1:0] g0, g1, g2, g3, g4, g5, g6, g7, g8;
  logic [3:0]    dir_out;
  logic [WD-1:0] gv [9];

  assign gv[0] = g0; assign gv[1] = g1; assign gv[2] = g2;
  assign gv[3] = g3; assign gv[4] = g4; assign gv[5] = g5;
  assign gv[6] = g6; assign gv[7] = g7; assign gv[8] = g8;

  nms_window_gen #(.W(WD), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mag_in(mag_in), .dir_in(dir_in),
`ifdef NMS_WINDOW_SOF_EN
    .sof_in(sof_in),
`endif
    .valid_out(valid_out),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5), .g6(g6), .g7(g7), .g8(g8),
    .dir_out(dir_out), .eof_out(eof_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: the image as written so far plus a raster position.
  int img_m [IH][IW];
  int img_d [IH][IW];
  int mx = 0, my = 0;
  int exp_g [9];
  int exp_dir = 0;
  bit exp_v = 0, exp_eof = 0;

  int pulses = 0;
  int first_g [9];
  int first_dir = 0;
  int q_g4 [$];
  int q_dir [$];
  int q_eof [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
    chk("eof_out", {31'd0, eof_out}, {31'd0, exp_eof});
    for (int k = 0; k < 9; k++) chk($sformatf("g%0d", k), {20'd0, gv[k]}, exp_g[k]);
    chk("dir_out", {28'd0, dir_out}, exp_dir);
  endtask

  task automatic cycle(input bit v, input int m, input int d, input bit s);
    valid_in = v;
    mag_in   = m[WD-1:0];
    dir_in   = d[3:0];
`ifdef NMS_WINDOW_SOF_EN
    sof_in   = s;
`endif
    exp_v   = 1'b0;
    exp_eof = 1'b0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      img_m[my][mx] = m & 32'hFFF;
      img_d[my][mx] = d & 32'hF;
      if (mx >= 2 && my >= 2) begin
        exp_v = 1'b1;
        for (int k = 0; k < 9; k++) exp_g[k] = img_m[my - 2 + k / 3][mx - 2 + k % 3];
        exp_dir = img_d[my - 1][mx - 1];
      end
      exp_eof = (mx == IW - 1) && (my == IH - 1);
      mx++;
      if (mx == IW) begin
        mx = 0;
        my++;
        if (my == IH) my = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (valid_out === 1'b1) begin
      pulses++;
      if (pulses == 1) begin
        for (int k = 0; k < 9; k++) first_g[k] = int'(gv[k]);
        first_dir = int'(dir_out);
      end
      q_g4.push_back(int'(g4));
      q_dir.push_back(int'(dir_out));
      q_eof.push_back(int'(eof_out));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    mx = 0; my = 0;
    exp_v = 1'b0; exp_eof = 1'b0; exp_dir = 0;
    for (int k = 0; k < 9; k++) exp_g[k] = 0;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input bit rnd, input bit sof_first);
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        int idle = 0;
        while (idle < 10 && $urandom_range(0, 99) < gap) begin
          cycle(1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)), 1'b0);
          idle++;
        end
        if (rnd)
          cycle(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 8)), sof_first && x == 0 && y == 0);
        else
          cycle(1'b1, 16 * y + x + base, ((x + y) % 8) + 1, sof_first && x == 0 && y == 0);
      end
    end
  endtask

  task automatic start_scenario();
    pulses = 0;
    q_g4.delete();
    q_dir.delete();
    q_eof.delete();
  endtask

  task automatic check_first_window(input string tag);
    int ref_g [9];
    ref_g = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    for (int k = 0; k < 9; k++) chk($sformatf("%s_first_g%0d", tag, k), first_g[k], ref_g[k]);
    chk({tag, "_first_dir"}, first_dir, 3);
  endtask

  initial begin
    for (int k = 0; k < 9; k++) exp_g[k] = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic frame and end-of-frame
    start_scenario();
    send_frame(0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    chk("basic_pulses", pulses, 6);
    check_first_window("basic");
    if (q_g4.size() == 6) begin
      chk("eof_last_g4", q_g4[5], 35);
      chk("eof_last_dir", q_dir[5], 6);
      chk("eof_last_flag", q_eof[5], 1);
      chk("eof_prev_flag", q_eof[4], 0);
    end else chk("eof_pulse_queue", q_g4.size(), 6);

    // Gapped input
    start_scenario();
    send_frame(0, 50, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    chk("gap_pulses", pulses, 6);
    check_first_window("gap");

    // Back-to-back frames
    start_scenario();
    send_frame(0, 0, 1'b0, 1'b0);
    send_frame(100, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    chk("b2b_pulses", pulses, 12);
    if (q_g4.size() == 12) chk("b2b_second_g4", q_g4[6], 117);
    else chk("b2b_pulse_queue", q_g4.size(), 12);

    // Reset mid-frame
    for (int i = 0; i < 14; i++) cycle(1'b1, 16 * (i / IW) + i % IW, (((i / IW) + (i % IW)) % 8) + 1, 1'b0);
    do_reset();
    start_scenario();
    send_frame(0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    chk("rst_pulses", pulses, 6);
    check_first_window("rst");

    // Random data with random gaps, two frames
    start_scenario();
    send_frame(0, 30, 1'b1, 1'b0);
    send_frame(0, 30, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    chk("rand_pulses", pulses, 12);

`ifdef NMS_WINDOW_SOF_EN
    // SOF resync after a partial frame
    for (int i = 0; i < 7; i++) cycle(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 8)), 1'b0);
    start_scenario();
    send_frame(0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0);
    chk("sof_pulses", pulses, 6);
    check_first_window("sof");
    // sof_in on a natural frame start
    start_scenario();
    send_frame(0, 20, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0);
    chk("sof_wrap_pulses", pulses, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
